// File: rtl/rx_ddr_burst_writer.sv
// Drains the RX prefetch FIFO into the DDR frame buffer as fixed-length AXI4 INCR write bursts.
// Optional macro RX_WR_BRESP_CHECK_EN adds a saturating err_cnt of non-OKAY write responses.
module rx_ddr_burst_writer #(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 128,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_BEATS = 259200,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  output logic                    fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    busy,
  output logic                    frame_done
`ifdef RX_WR_BRESP_CHECK_EN
  ,
  output logic [15:0]             err_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [31:0]           BURST_BEATS = 32'(BURST_LEN);
  localparam logic [31:0]           FRAME_TOTAL = 32'(FRAME_BEATS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   offset_q, offset_d;
  logic [31:0]             frame_cnt_q, frame_cnt_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    awvalid_q, awvalid_d;
  logic                    bready_q, bready_d;
  logic                    frame_done_q, frame_done_d;
  logic                    start_pend_q, start_pend_d;
  logic                    w_hs;
  logic                    b_hs;
  logic [31:0]             frame_next;

  assign wvalid     = (state_q == DATA) && fifo_rd_vld;
  assign wdata      = fifo_rd_data;
  assign wstrb      = '1;
  assign wlast      = (state_q == DATA) && (beat_cnt_q == LAST_BEAT);
  assign w_hs       = wvalid && wready;
  assign fifo_rd_en = w_hs;
  assign b_hs       = bready_q && bvalid;
  assign frame_next = frame_cnt_q + BURST_BEATS;

  assign awaddr     = BASE_ADDR + offset_q;
  assign awlen      = LAST_BEAT;
  assign awvalid    = awvalid_q;
  assign bready     = bready_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    frame_cnt_d  = frame_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    awvalid_d    = awvalid_q;
    bready_d     = bready_q;
    frame_done_d = 1'b0;
    start_pend_d = start_pend_q;
    // A restart outside IDLE is held until the burst in flight has fully retired.
    if (frame_start && (state_q != IDLE)) begin
      start_pend_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (frame_start || start_pend_q) begin
          offset_d     = '0;
          frame_cnt_d  = '0;
          start_pend_d = 1'b0;
        end
        if (fifo_rd_vld) begin
          state_d   = ADDR;
          awvalid_d = 1'b1;
        end
      end
      ADDR: begin
        if (awvalid_q && awready) begin
          awvalid_d  = 1'b0;
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (wlast) begin
            state_d  = RESP;
            bready_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          state_d  = IDLE;
          if (frame_next >= FRAME_TOTAL) begin
            offset_d     = '0;
            frame_cnt_d  = '0;
            frame_done_d = 1'b1;
          end else begin
            offset_d    = offset_q + BURST_BYTES;
            frame_cnt_d = frame_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RX_WR_BRESP_CHECK_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (b_hs && (bresp != 2'b00) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      offset_q     <= '0;
      frame_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      awvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      frame_cnt_q  <= frame_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      awvalid_q    <= awvalid_d;
      bready_q     <= bready_d;
      frame_done_q <= frame_done_d;
      start_pend_q <= start_pend_d;
    end
  end

endmodule

// File: tb/tb_rx_ddr_burst_writer.sv
// Directed bench for rx_ddr_burst_writer with a 32-beat frame (two 16-beat bursts of 0x100 bytes).
module tb_rx_ddr_burst_writer;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int BL = 16;
  localparam int FB = 32;
  localparam int NO_FS   = -1;
  localparam int RESP_FS = 99;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          fifo_rd_vld;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic          busy;
  logic          frame_done;
`ifdef RX_WR_BRESP_CHECK_EN
  logic [15:0]   err_cnt;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] head = 32'd0;
  logic [31:0] exp_word = 32'd0;

  always #5 clk = ~clk;

  rx_ddr_burst_writer #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .BURST_LEN   (BL),
    .FRAME_BEATS (FB),
    .BASE_ADDR   ('0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .awaddr       (awaddr),
    .awlen        (awlen),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .wlast        (wlast),
    .wvalid       (wvalid),
    .wready       (wready),
    .bresp        (bresp),
    .bvalid       (bvalid),
    .bready       (bready),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef RX_WR_BRESP_CHECK_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  function automatic logic [DW-1:0] word_of(input logic [31:0] n);
    return {n, ~n, n ^ 32'hA5A5_5A5A, n};
  endfunction

  // FIFO model: an endless numbered word stream that advances only on pops.
  assign fifo_rd_data = word_of(head);
  always @(posedge clk) if (fifo_rd_en) head <= head + 32'd1;

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one burst from IDLE through RESP back to IDLE, starting and ending 1 time unit after an edge.
  task automatic run_burst(input logic [AW-1:0] exp_addr, input int aw_delay, input int starve_at,
                           input int starve_len, input bit wr_toggle, input int fs_beat,
                           input logic [1:0] resp, input bit exp_done);
    int beats;
    int c;
    bit fs_done;
    fifo_rd_vld = 1'b1;
    awready = 1'b0;
    wready = 1'b1;
    bvalid = 1'b0;
    #1;
    check_output("idle_awvalid", awvalid, 1'b0);
    check_output("idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i <= aw_delay; i++) begin
      awready = (i == aw_delay);
      #1;
      check_output("aw_valid", awvalid, 1'b1);
      check_output("aw_addr", awaddr, exp_addr);
      check_output("aw_len", awlen, 8'd15);
      check_output("aw_no_wvalid", wvalid, 1'b0);
      check_output("aw_no_pop", fifo_rd_en, 1'b0);
      @(posedge clk); #1;
    end
    awready = 1'b0;
    beats = 0;
    c = 0;
    fs_done = 1'b0;
    while (beats < BL && c < 200) begin
      fifo_rd_vld = !(c >= starve_at && c < starve_at + starve_len);
      wready = wr_toggle ? (c % 2 == 0) : 1'b1;
      frame_start = (beats == fs_beat) && !fs_done;
      fs_done = fs_done | frame_start;
      #1;
      check_output("w_valid", wvalid, fifo_rd_vld);
      check_output("w_pop", fifo_rd_en, fifo_rd_vld && wready);
      if (fifo_rd_vld && wready) begin
        check_output("w_data", wdata, word_of(exp_word));
        check_output("w_last", wlast, beats == BL - 1);
        check_output("w_strb", wstrb, {(DW/8){1'b1}});
        exp_word = exp_word + 32'd1;
        beats++;
      end
      @(posedge clk); #1;
      c++;
    end
    frame_start = 1'b0;
    fifo_rd_vld = 1'b0;
    wready = 1'b0;
    if (beats < BL) check_output("data_timeout", beats, BL);
    bresp = resp;
    bvalid = 1'b1;
    if (fs_beat == RESP_FS) frame_start = 1'b1;
    #1;
    check_output("resp_bready", bready, 1'b1);
    check_output("resp_busy", busy, 1'b1);
    check_output("resp_no_done", frame_done, 1'b0);
    @(posedge clk); #1;
    bvalid = 1'b0;
    bresp = 2'b00;
    frame_start = 1'b0;
    #1;
    check_output("post_busy", busy, 1'b0);
    check_output("post_bready", bready, 1'b0);
    check_output("post_frame_done", frame_done, exp_done);
    @(posedge clk); #1;
    check_output("done_single_pulse", frame_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    frame_start = 1'b0;
    fifo_rd_vld = 1'b0;
    awready = 1'b0;
    wready = 1'b0;
    bresp = 2'b00;
    bvalid = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_output("rst_awvalid", awvalid, 1'b0);
    check_output("rst_wvalid", wvalid, 1'b0);
    check_output("rst_wlast", wlast, 1'b0);
    check_output("rst_bready", bready, 1'b0);
    check_output("rst_rd_en", fifo_rd_en, 1'b0);
    check_output("rst_frame_done", frame_done, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_awaddr", awaddr, 28'h0);
    check_output("rst_awlen", awlen, 8'd15);
`ifdef RX_WR_BRESP_CHECK_EN
    check_output("rst_err_cnt", err_cnt, 16'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single burst, then starvation (ends frame), then backpressure in the new frame.
    run_burst(28'h000, 0, -1, 0, 1'b0, NO_FS, 2'b00, 1'b0);
    run_burst(28'h100, 0, 4, 5, 1'b0, NO_FS, 2'b00, 1'b1);
    run_burst(28'h000, 3, -1, 0, 1'b1, NO_FS, 2'b00, 1'b0);
    // Restart mid-burst on the last burst of a frame, then on the first.
    run_burst(28'h100, 0, -1, 0, 1'b0, 5, 2'b10, 1'b1);
    run_burst(28'h000, 0, -1, 0, 1'b0, 5, 2'b10, 1'b0);
    run_burst(28'h000, 0, -1, 0, 1'b0, NO_FS, 2'b00, 1'b0);
    // Restart while idle.
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    check_output("idle_fs_busy", busy, 1'b0);
    run_burst(28'h000, 0, -1, 0, 1'b0, NO_FS, 2'b00, 1'b0);
    // Restart coincident with the final response of a frame.
    run_burst(28'h100, 0, -1, 0, 1'b0, RESP_FS, 2'b00, 1'b1);
    run_burst(28'h000, 0, -1, 0, 1'b0, NO_FS, 2'b00, 1'b0);
`ifdef RX_WR_BRESP_CHECK_EN
    check_output("err_cnt", err_cnt, 16'd2);
`endif

    // Mid-burst reset at offset 0x100 after three beats.
    fifo_rd_vld = 1'b1;
    awready = 1'b1;
    wready = 1'b1;
    @(posedge clk); #1;
    check_output("mr_awaddr", awaddr, 28'h100);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    exp_word = exp_word + 32'd3;
    check_output("mr_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_output("mr_busy", busy, 1'b0);
    check_output("mr_wvalid", wvalid, 1'b0);
    check_output("mr_rd_en", fifo_rd_en, 1'b0);
    check_output("mr_awaddr_base", awaddr, 28'h0);
    fifo_rd_vld = 1'b0;
    awready = 1'b0;
    wready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_burst(28'h000, 0, -1, 0, 1'b0, NO_FS, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_ddr_burst_writer.md
# rx_ddr_burst_writer

Drains 128-bit words from the RX prefetch FIFO and writes them to the DDR frame buffer as fixed-length AXI4 INCR write bursts. It sits directly downstream of the RX FIFO and consumes its `rd_vld`/`rd_en`/`rd_data` prefetch interface. On the other side it drives the write-address, write-data and write-response channels of the DDR controller port. It tracks the linear frame address, wraps at the end of each frame and reports frame completion.

## Interface
- `ADDR_WIDTH`, 28: AXI byte-address width.
- `DATA_WIDTH`, 128: beat width. Must equal the FIFO read width.
- `BURST_LEN`, 16: beats per burst, 1..256.
- `FRAME_BEATS`, 259200: beats per frame. Must be a multiple of `BURST_LEN`.
- `BASE_ADDR`, 0: frame buffer byte base address. Must be aligned to `BURST_LEN*DATA_WIDTH/8`.
- `clk` in 1: single clock for FIFO and AXI.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `frame_start` in 1: one-cycle pulse that restarts the address at `BASE_ADDR`.
- `fifo_rd_vld` in 1: FIFO head word valid.
- `fifo_rd_data` in `DATA_WIDTH`: FIFO head word.
- `fifo_rd_en` out 1: pop strobe for the FIFO.
- `awaddr` out `ADDR_WIDTH`, `awlen` out 8, `awvalid` out 1, `awready` in 1: AXI write-address channel.
- `wdata` out `DATA_WIDTH`, `wstrb` out `DATA_WIDTH/8`, `wlast` out 1, `wvalid` out 1, `wready` in 1: AXI write-data channel.
- `bresp` in 2, `bvalid` in 1, `bready` out 1: AXI write-response channel.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `frame_done` out 1: one-cycle pulse after the last burst of a frame.
- `err_cnt` out 16: only present with `RX_WR_BRESP_CHECK_EN`.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- **IDLE → ADDR** when `fifo_rd_vld` is 1. `awvalid` rises on the next cycle.
- **ADDR → DATA** on `awvalid && awready`.
  - `awaddr = BASE_ADDR + offset`.
  - `awlen = BURST_LEN-1`.
  - `awaddr` and `awlen` are held stable while `awvalid` is high.
- **DATA** (the burst does not wait for the FIFO to fill):
  - `wvalid = fifo_rd_vld`; gaps in `wvalid` are allowed.
  - `wdata = fifo_rd_data`; `wstrb` is all ones.
  - `fifo_rd_en = wvalid && wready`, which is exactly the W handshake.
  - The beat counter increments on each handshake.
  - `wlast` is 1 when the counter equals `BURST_LEN-1`.
  - After the `wlast` handshake the FSM moves to RESP.
- **RESP**: `bready` is 1. On `bvalid` the FSM returns to IDLE and the offset advances.
  - Offset advances by `BURST_LEN*DATA_WIDTH/8`.
  - When the beat total reaches `FRAME_BEATS`, the offset wraps to 0 and `frame_done` pulses.
- Address arithmetic: offset is `ADDR_WIDTH` bits; the frame beat counter is 32 bits.
- `frame_start` handling:
  - In IDLE, the offset and frame beat counter clear on the next edge.
  - In any other state, the request is latched and applied when the FSM returns to IDLE. The burst in flight is never truncated.
- Simultaneous `frame_start` and last-burst `bvalid`: `frame_done` still pulses and the offset goes to 0.
- AW and W never overlap: W starts only after the AW handshake.

## Timing
- Reset values: FSM in IDLE; `awvalid`, `wvalid`, `wlast`, `bready`, `fifo_rd_en`, `frame_done`, `busy` all 0; `awaddr = BASE_ADDR`; `awlen = BURST_LEN-1`; `err_cnt` 0.
- Mid-burst reset: the FSM aborts immediately to IDLE and the offset returns to `BASE_ADDR`. The partial burst is not completed.
- Latency from `fifo_rd_vld` rising in IDLE to `awvalid`: 1 cycle.
- Minimum burst time (`awready`, `wready`, `bvalid` always 1, FIFO never empty): 1 ADDR + `BURST_LEN` DATA + 1 RESP + 1 IDLE.
- `wvalid`, `wdata`, `wlast` are combinational from the FIFO head and the beat counter. `awvalid` and `bready` are registered.
- `frame_done` asserts in the cycle after the final `bvalid` handshake.

## Configuration
- `RX_WR_BRESP_CHECK_EN` defined: each B handshake with `bresp != 2'b00` increments `err_cnt`. The counter saturates at 16'hFFFF.
- Undefined: `err_cnt` is absent and `bresp` is ignored.
- Data-path behaviour is identical in both builds.

## Test plan
- **Single burst:** reset, then FIFO holds 16 words 0..15, all ready signals 1 → one AW with `awaddr`=0x0 and `awlen`=15; 16 beats with data 0..15; `wlast` on beat 15; 16 pops; FSM back in IDLE.
- **FIFO starvation:** `fifo_rd_vld` drops for 5 cycles mid-burst → `wvalid` is 0 for those 5 cycles; no pop and no counter change; burst completes with 16 beats.
- **Backpressure:** `wready` toggles 1-0 and `awready` is delayed 3 cycles → AW address stable while waiting; no pop without a handshake; data order preserved.
- **Frame wrap:** `FRAME_BEATS`=32 → bursts at 0x000 and 0x100; `frame_done` pulses once; third burst at 0x000.
- **frame_start mid-burst:** pulse on beat 5 of the burst at 0x100 → the burst finishes at 0x100; the next burst goes to `BASE_ADDR`.
- **Response error:** `bresp`=2'b10 on two bursts with `RX_WR_BRESP_CHECK_EN` defined → `err_cnt`=2; addressing is unaffected.
